// File: rtl/servo_seq_ctrl.sv
// Four-joint servo sequencer: frame timer, OFF/HOME/RUN/PARK control FSM and
// per-joint rate-limited position ramps feeding four PWM instances.
module servo_seq_ctrl #(
    parameter int FRAME_CYCLES = 1_000_000,
    parameter int POS_MAX      = 41,
    parameter int HOME_POS     = 8,
    parameter int STEP         = 1,
    parameter int HOME_FRAMES  = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm_en,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_ch,
    input  logic [15:0] cmd_pos,
    output logic [63:0] pos_data,
    output logic [3:0]  pwm_en,
    output logic        frame_tick,
    output logic        busy,
    output logic        err_range
);

    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int PW = $clog2(POS_MAX + 1);
    localparam int HW = $clog2(HOME_FRAMES + 1);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_HOME = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_PARK = 2'd3;

    localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_CYCLES - 1);
    localparam logic [HW-1:0] HOME_LAST = HW'(HOME_FRAMES - 1);
    localparam logic [PW-1:0] HOME_P    = PW'(HOME_POS);
    localparam logic [PW-1:0] MAX_P     = PW'(POS_MAX);
    // A step larger than the whole legal range behaves like a jump to target.
    localparam logic [PW-1:0] STEP_P    = (STEP > POS_MAX) ? MAX_P : PW'(STEP);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [PW-1:0] cur_q [4];
    logic [PW-1:0] cur_d [4];
    logic [PW-1:0] tgt_q [4];
    logic [PW-1:0] tgt_d [4];
    logic          err_q, err_d;

    logic          all_home;
    logic          cmd_accept;
    logic          cmd_over;
    logic [PW-1:0] cmd_clamped;
    logic [PW-1:0] diff;

    always_comb begin
        frame_tick  = (state_q != ST_OFF) && (cnt_q == CNT_LAST);
        cmd_ready   = (state_q == ST_RUN);
        pwm_en      = (state_q != ST_OFF) ? 4'hF : 4'h0;
        err_range   = err_q;
        cmd_accept  = cmd_valid && cmd_ready;
        cmd_over    = cmd_pos > 16'(POS_MAX);
        cmd_clamped = cmd_over ? MAX_P : cmd_pos[PW-1:0];
        all_home    = 1'b1;
        busy        = 1'b0;
        pos_data    = '0;
        for (int i = 0; i < 4; i++) begin
            if (cur_q[i] != HOME_P) all_home = 1'b0;
            if (cur_q[i] != tgt_q[i]) busy = 1'b1;
            pos_data[16*i +: 16] = 16'(cur_q[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:  if (arm_en) state_d = ST_HOME;
            ST_HOME: begin
                if (!arm_en) state_d = ST_OFF;
                else if (frame_tick && (hcnt_q == HOME_LAST)) state_d = ST_RUN;
            end
            ST_RUN:  if (!arm_en) state_d = ST_PARK;
            ST_PARK: begin
                if (arm_en) state_d = ST_RUN;
                else if (frame_tick && all_home) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase

        if ((state_q == ST_OFF) || (state_d == ST_OFF) || (cnt_q == CNT_LAST))
            cnt_d = '0;
        else
            cnt_d = cnt_q + CW'(1);

        if (state_q != ST_HOME)
            hcnt_d = '0;
        else if (frame_tick)
            hcnt_d = hcnt_q + HW'(1);
        else
            hcnt_d = hcnt_q;

        err_d = cmd_accept && cmd_over;
    end

    // Steps use the registered target, so a command landing on a tick edge
    // only takes effect from the following frame.
    always_comb begin
        diff = '0;
        for (int i = 0; i < 4; i++) begin
            cur_d[i] = cur_q[i];
            tgt_d[i] = tgt_q[i];
            if (frame_tick) begin
                if (tgt_q[i] > cur_q[i]) begin
                    diff     = tgt_q[i] - cur_q[i];
                    cur_d[i] = (diff > STEP_P) ? cur_q[i] + STEP_P : tgt_q[i];
                end else if (tgt_q[i] < cur_q[i]) begin
                    diff     = cur_q[i] - tgt_q[i];
                    cur_d[i] = (diff > STEP_P) ? cur_q[i] - STEP_P : tgt_q[i];
                end
            end
            if (cmd_accept && (cmd_ch == 2'(i))) tgt_d[i] = cmd_clamped;
            if ((state_q == ST_RUN) && !arm_en) tgt_d[i] = HOME_P;
            if ((state_q == ST_OFF) || (state_q == ST_HOME)) begin
                cur_d[i] = HOME_P;
                tgt_d[i] = HOME_P;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cur_q[i] <= HOME_P;
                tgt_q[i] <= HOME_P;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            err_q   <= err_d;
            for (int i = 0; i < 4; i++) begin
                cur_q[i] <= cur_d[i];
                tgt_q[i] <= tgt_d[i];
            end
        end
    end

endmodule
